reg_file_param: RTL and testbench

Parametrised general-purpose register file: two combinational read ports and one synchronous write port, with configurable data width and depth. Successor to the fixed 64x32 register file used in the single-cycle datapath. Adds a hardwired-zero register option, a sequenced post-reset clear with a busy handshake, and reporting of dropped writes. Sits between the decode stage (RS1/RS2/RD) and the ALU/writeback mux.

---
 rtl/reg_file_param.sv | 116 +++++++++++
 tb/tb_reg_file_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with two combinational read
// ports and one synchronous write port. After reset, a clear sequence zeroes
// every entry while Busy is high. Writes requested during that sequence are
// discarded and reported on WriteDropped one cycle later.
// Optional build macro REGFILE_BYPASS_EN enables write-first forwarding from
// WriteData to the read ports.
module reg_file_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  input  logic [ADDR_W-1:0] RD,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Busy,
  output logic              WriteDropped
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              dropped_q, dropped_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr_to_zero;
  assign wr_to_zero = (ZERO_REG != 0) && (RD == '0);

  // State register, clear counter and drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      dropped_q <= dropped_d;
    end
  end

  // Next-state logic: walk the counter through every entry, then go READY
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    dropped_d = 1'b0;
    if (state_q == CLEAR) begin
      dropped_d = RegWrite;
      if (clr_cnt_q == LAST_IDX) begin
        // Counter holds on the final entry rather than wrapping to 0.
        state_d = READY;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      end
    end
  end

  // Array write: clear writes during CLEAR, user writes during READY
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (RegWrite && !wr_to_zero) begin
        mem_q[RD] <= WriteData;
      end
    end
  end

  // Read port 1: array, optional forwarding, zero entry, clear mask
  always_comb begin
    ReadData1 = mem_q[RS1];
`ifdef REGFILE_BYPASS_EN
    if ((state_q == READY) && RegWrite && (RS1 == RD)) begin
      ReadData1 = WriteData;
    end
`endif
    if ((ZERO_REG != 0) && (RS1 == '0)) begin
      ReadData1 = '0;
    end
    if (state_q == CLEAR) begin
      ReadData1 = '0;
    end
  end

  // Read port 2: same priority order as port 1
  always_comb begin
    ReadData2 = mem_q[RS2];
`ifdef REGFILE_BYPASS_EN
    if ((state_q == READY) && RegWrite && (RS2 == RD)) begin
      ReadData2 = WriteData;
    end
`endif
    if ((ZERO_REG != 0) && (RS2 == '0)) begin
      ReadData2 = '0;
    end
    if (state_q == CLEAR) begin
      ReadData2 = '0;
    end
  end

  assign Busy         = (state_q == CLEAR);
  assign WriteDropped = dropped_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param (DATA_W=64, ADDR_W=5, ZERO_REG=1).
// Inputs are driven 1 time unit after posedge; expectations are queued at
// drive time and compared 3 units later, well before the next edge.
module tb_reg_file_param;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] RS1, RS2, RD;
  logic          RegWrite;
  logic [DW-1:0] ReadData1, ReadData2;
  logic          Busy, WriteDropped;

  always #5 clk = ~clk;

  reg_file_param #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .ZERO_REG(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .WriteData   (WriteData),
    .RS1         (RS1),
    .RS2         (RS2),
    .RD          (RD),
    .RegWrite    (RegWrite),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .Busy        (Busy),
    .WriteDropped(WriteDropped)
  );

  typedef struct {
    string         tag;
    int            sel;   // 0 ReadData1, 1 ReadData2, 2 Busy, 3 WriteDropped
    logic [DW-1:0] exp;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] model [DEPTH];

  task automatic check_val(input string tag, input logic [DW-1:0] obs,
                           input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [DW-1:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t          e;
    logic [DW-1:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = ReadData1;
        1:       obs = ReadData2;
        2:       obs = {63'b0, Busy};
        default: obs = {63'b0, WriteDropped};
      endcase
      check_val(e.tag, obs, e.exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] rs, input logic we,
                                             input logic [AW-1:0] rd,
                                             input logic [DW-1:0] wd);
    if (rs == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && rs == rd) return wd;
`endif
    return model[rs];
  endfunction

  // One READY cycle: drive, queue expectations, compare, clock, update model
  task automatic do_cycle(input string tg, input logic we, input logic [AW-1:0] rd,
                          input logic [DW-1:0] wd, input logic [AW-1:0] rs1,
                          input logic [AW-1:0] rs2);
    RegWrite = we; RD = rd; WriteData = wd; RS1 = rs1; RS2 = rs2;
    push_exp({tg, "_rd1"}, 0, exp_read(rs1, we, rd, wd));
    push_exp({tg, "_rd2"}, 1, exp_read(rs2, we, rd, wd));
    push_exp({tg, "_busy"}, 2, '0);
    push_exp({tg, "_drop"}, 3, '0);
    #3;
    drain();
    next_cycle();
    if (we && rd != 0) model[rd] = wd;
    RegWrite = 1'b0;
  endtask

  // Called with reset just deasserted; follows the clear until Busy falls
  task automatic run_clear(input string tg, input int drop_at, input int reassert_at);
    int   n;
    logic drop_prev;
    n = 0;
    drop_prev = 1'b0;
    while (Busy && n < 200) begin
      RS1 = AW'($urandom); RS2 = AW'($urandom);
      RD = 5'd3; WriteData = 64'd7;
      RegWrite = (n == drop_at);
      if (n == reassert_at) begin
        reset = 1'b1;
        reassert_at = -1;
      end
      push_exp({tg, "_rd1"}, 0, '0);
      push_exp({tg, "_rd2"}, 1, '0);
      push_exp({tg, "_drop"}, 3, {63'b0, drop_prev});
      #3;
      drain();
      drop_prev = RegWrite && !reset;
      next_cycle();
      RegWrite = 1'b0;
      if (reset) begin
        reset = 1'b0;
        n = 0;
      end else begin
        n++;
      end
    end
    check_val({tg, "_len"}, 64'(n), 64'd32);
    push_exp({tg, "_end_busy"}, 2, '0);
    push_exp({tg, "_end_drop"}, 3, {63'b0, drop_prev});
    #3;
    drain();
    next_cycle();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic read_all(input string tg);
    for (int i = 0; i < DEPTH; i++) begin
      RS1 = AW'(i);
      RS2 = AW'(DEPTH - 1 - i);
      push_exp({tg, "_rd1"}, 0, exp_read(RS1, 1'b0, '0, '0));
      push_exp({tg, "_rd2"}, 1, exp_read(RS2, 1'b0, '0, '0));
      #1;
      drain();
    end
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteData = '0;
    RS1 = '0; RS2 = '0; RD = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset held two cycles, then the first full clear
    next_cycle();
    next_cycle();
    push_exp("rst_busy", 2, 64'd1);
    push_exp("rst_rd1", 0, '0);
    push_exp("rst_rd2", 1, '0);
    push_exp("rst_drop", 3, '0);
    #3;
    drain();
    reset = 1'b0;
    run_clear("clr1", -1, -1);
    read_all("after_clr1");

    // Write then read on both ports
    do_cycle("w20", 1'b1, 5'd20, 64'd21, 5'd5, 5'd6);
    do_cycle("r20", 1'b0, 5'd0, 64'd0, 5'd20, 5'd20);
    check_val("r20_const", ReadData1, 64'd21);

    // Hardwired zero entry ignores writes and does not report a drop
    do_cycle("w0", 1'b1, 5'd0, 64'hFFFF, 5'd1, 5'd2);
    do_cycle("r0", 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);

    // Read-during-write on the same index, then the registered value
    do_cycle("w10", 1'b1, 5'd10, 64'd11, 5'd1, 5'd2);
    do_cycle("rdw10", 1'b1, 5'd10, 64'd32, 5'd10, 5'd10);
    do_cycle("r10", 1'b0, 5'd0, 64'd0, 5'd10, 5'd10);
    check_val("r10_const", ReadData2, 64'd32);
    do_cycle("rdw0", 1'b1, 5'd0, 64'd5, 5'd0, 5'd0);

    // Random traffic checked against the bench model
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] rd;
      rd = AW'($urandom);
      do_cycle("rand", ($urandom_range(0, 3) != 0), rd, {$urandom, $urandom},
               AW'($urandom), (i % 3 == 0) ? rd : AW'($urandom));
    end

    // Reset with a write dropped at clear cycle 5; entry 3 must come back 0
    do_cycle("w3", 1'b1, 5'd3, 64'd55, 5'd1, 5'd2);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    run_clear("clr2", 5, -1);
    read_all("after_clr2");

    // Reset reasserted at clear cycle 10 restarts the full sequence
    do_cycle("w7", 1'b1, 5'd7, 64'hDEAD, 5'd1, 5'd2);
    do_cycle("w31", 1'b1, 5'd31, 64'hBEEF, 5'd1, 5'd2);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    run_clear("clr3", -1, 10);
    read_all("after_clr3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
